// File: rtl/instr_fetch_if.sv
// Instruction fetch bus bundle.
// Groups the instruction-memory req/ack port and the decode handoff port.
//   mem_req/mem_addr         : fetch request, driven by the fetch unit
//   mem_ack/mem_err/mem_rdata: memory response, qualified by mem_ack
//   instr/instr_pc/instr_valid: fetched word handed to decode
//   instr_ready              : decode accepts instr when high with instr_valid
// master = fetch unit side, slave = memory/decode side.
interface instr_fetch_if #(
  parameter int unsigned XLEN = 32
);
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ack;
  logic            mem_err;
  logic [XLEN-1:0] mem_rdata;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_valid;
  logic            instr_ready;

  modport master (
    output mem_req, mem_addr, instr, instr_pc, instr_valid,
    input  mem_ack, mem_err, mem_rdata, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr, instr_pc, instr_valid,
    output mem_ack, mem_err, mem_rdata, instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage.
// Latches the PC on start, performs one word fetch over the req/ack memory
// port, holds the instruction until decode accepts it, then pulses
// pc_advance for one cycle. Misaligned PCs, bus errors and timeouts are
// reported as faults instead of an instruction.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   pc, start           : fetch address and fetch request (honoured in IDLE)
//   flush               : abandon fetch / drop held instruction / clear fault
//   bus                 : memory port and decode handoff (master side)
//   pc_advance          : one-cycle pulse after decode accepts instr
//   fault, fault_cause  : pending fault, 01 misaligned, 10 bus err, 11 timeout
//   fault_clear         : acknowledge fault, return to IDLE
module instr_fetch #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic            start,
  input  logic            flush,
  instr_fetch_if.master   bus,
  output logic            pc_advance,
  output logic            fault,
  output logic [1:0]      fault_cause,
  input  logic            fault_clear
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_FAULT} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] count;
  logic       discard;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      count           <= '0;
      discard         <= 1'b0;
      bus.mem_req     <= 1'b0;
      bus.mem_addr    <= '0;
      bus.instr       <= '0;
      bus.instr_pc    <= '0;
      bus.instr_valid <= 1'b0;
      pc_advance      <= 1'b0;
      fault           <= 1'b0;
      fault_cause     <= 2'b00;
    end else begin
      pc_advance <= 1'b0;
      case (state)
        S_IDLE: begin
          // A start coinciding with pc_advance sees a stale pc: ignore it.
          if (start && !pc_advance) begin
            bus.instr_pc <= pc;
            if (pc[1:0] != 2'b00) begin
              fault       <= 1'b1;
              fault_cause <= 2'b01;
              state       <= S_FAULT;
            end else begin
              bus.mem_addr <= pc;
              bus.mem_req  <= 1'b1;
              count        <= '0;
              state        <= S_BUSY;
            end
          end
        end

        S_BUSY: begin
          // A flush in the same cycle as the ack or timeout drops the result
          // just like an earlier flush would.
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            if (discard || flush) begin
              discard <= 1'b0;
              state   <= S_IDLE;
            end else if (bus.mem_err) begin
              fault       <= 1'b1;
              fault_cause <= 2'b10;
              state       <= S_FAULT;
            end else begin
              bus.instr       <= bus.mem_rdata;
              bus.instr_valid <= 1'b1;
              state           <= S_DONE;
            end
          end else if (count == TMO_LAST) begin
            bus.mem_req <= 1'b0;
            if (discard || flush) begin
              discard <= 1'b0;
              state   <= S_IDLE;
            end else begin
              fault       <= 1'b1;
              fault_cause <= 2'b11;
              state       <= S_FAULT;
            end
          end else begin
            if (count != 8'hFF) count <= count + 8'd1;
            // Request stays up until acked; only the result is dropped.
            if (flush) discard <= 1'b1;
          end
        end

        S_DONE: begin
          if (flush) begin
            bus.instr_valid <= 1'b0;
            state           <= S_IDLE;
          end else if (bus.instr_ready) begin
            bus.instr_valid <= 1'b0;
            pc_advance      <= 1'b1;
            state           <= S_IDLE;
          end
        end

        S_FAULT: begin
          if (fault_clear || flush) begin
            fault       <= 1'b0;
            fault_cause <= 2'b00;
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam int K_REQ   = 0;
  localparam int K_INSTR = 1;
  localparam int K_FAULT = 2;
  localparam int K_ADV   = 3;

  typedef struct {
    int          kind;
    logic [31:0] a;    // req: addr, instr: word, fault: cause
    logic [31:0] b;    // instr/fault: instr_pc
    int          len;  // req: expected cycles mem_req high (0 = unchecked)
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        start, flush, fault_clear;
  logic        pc_advance, fault;
  logic [1:0]  fault_cause;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t q[$];

  instr_fetch_if #(.XLEN(32)) bus ();

  instr_fetch #(.XLEN(32), .TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .start       (start),
    .flush       (flush),
    .bus         (bus),
    .pc_advance  (pc_advance),
    .fault       (fault),
    .fault_cause (fault_cause),
    .fault_clear (fault_clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input logic [31:0] a, input logic [31:0] b, input int len);
    exp_t e;
    e.kind = kind; e.a = a; e.b = b; e.len = len;
    q.push_back(e);
  endtask

  // Monitor: pops one expectation per DUT output event.
  logic        p_req = 1'b0, p_val = 1'b0, p_flt = 1'b0, p_adv = 1'b0;
  logic [31:0] cur_addr, cur_instr, cur_ipc;
  int          cur_len = 0, req_cnt = 0;

  task automatic pop(input int kind, output exp_t e);
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d expected none at %0t", kind, $time);
      e.kind = kind; e.a = '0; e.b = '0; e.len = 0;
    end else begin
      e = q.pop_front();
      if (e.kind != kind) begin
        n_bad++;
        $display("FAIL event_kind: got %0d expected %0d at %0t", kind, e.kind, $time);
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.mem_req && !p_req) begin
      pop(K_REQ, e);
      cur_addr = e.a; cur_len = e.len; req_cnt = 0;
    end
    if (bus.mem_req) begin
      req_cnt++;
      check("mem_addr", bus.mem_addr, cur_addr);
    end
    if (!bus.mem_req && p_req && cur_len != 0)
      check("mem_req_len", 32'(req_cnt), 32'(cur_len));

    if (bus.instr_valid && !p_val) begin
      pop(K_INSTR, e);
      cur_instr = e.a; cur_ipc = e.b;
    end
    if (bus.instr_valid) begin
      check("instr", bus.instr, cur_instr);
      check("instr_pc", bus.instr_pc, cur_ipc);
    end

    if (fault && !p_flt) begin
      pop(K_FAULT, e);
      check("fault_cause", {30'd0, fault_cause}, e.a);
      check("fault_pc", bus.instr_pc, e.b);
    end

    if (pc_advance) begin
      if (p_adv) check("pc_advance_width", 32'd2, 32'd1);
      else pop(K_ADV, e);
    end

    p_req = bus.mem_req; p_val = bus.instr_valid; p_flt = fault; p_adv = pc_advance;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pc = '0; start = 1'b0; flush = 1'b0; fault_clear = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_err = 1'b0; bus.mem_rdata = '0; bus.instr_ready = 1'b0;
    step(); step();
    check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_instr", bus.instr, 32'd0);
    check("rst_instr_pc", bus.instr_pc, 32'd0);
    check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rst_fault", {29'd0, fault, fault_cause}, 32'd0);
    rst = 1'b0;
    step();

    // Aligned fetch, ack 3 cycles after mem_req; pc wiggles during BUSY.
    push(K_REQ, 32'h100, '0, 4);
    push(K_INSTR, 32'h00A00093, 32'h100, 0);
    push(K_ADV, '0, '0, 0);
    pc = 32'h100; start = 1'b1; step(); start = 1'b0;
    pc = 32'h999;
    step(); step(); step();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h00A00093; step();
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    bus.instr_ready = 1'b1; step(); bus.instr_ready = 1'b0;
    check("adv_pulse", {31'd0, pc_advance}, 32'd1);
    // start during the pc_advance cycle must be ignored
    pc = 32'h200; start = 1'b1; step(); start = 1'b0;
    check("adv_gone", {31'd0, pc_advance}, 32'd0);
    step(); step();

    // Back-pressure: ready held low for 5 cycles.
    push(K_REQ, 32'h104, '0, 1);
    push(K_INSTR, 32'h00B00113, 32'h104, 0);
    push(K_ADV, '0, '0, 0);
    pc = 32'h104; start = 1'b1; step(); start = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h00B00113; step();
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, bus.instr_valid}, 32'd1);
      check("bp_no_adv", {31'd0, pc_advance}, 32'd0);
      step();
    end
    bus.instr_ready = 1'b1; step(); bus.instr_ready = 1'b0;
    check("bp_adv", {31'd0, pc_advance}, 32'd1);
    step(); step();

    // Misaligned: no request; start in FAULT ignored; fault_clear.
    push(K_FAULT, 32'd1, 32'h102, 0);
    pc = 32'h102; start = 1'b1; step(); start = 1'b0;
    check("mis_fault", {31'd0, fault}, 32'd1);
    pc = 32'h400; start = 1'b1; step(); start = 1'b0;
    step();
    fault_clear = 1'b1; step(); fault_clear = 1'b0;
    check("mis_clear", {29'd0, fault, fault_cause}, 32'd0);
    step();

    // Bus error.
    push(K_REQ, 32'h108, '0, 2);
    push(K_FAULT, 32'd2, 32'h108, 0);
    pc = 32'h108; start = 1'b1; step(); start = 1'b0;
    step();
    bus.mem_ack = 1'b1; bus.mem_err = 1'b1; bus.mem_rdata = 32'h12345678; step();
    bus.mem_ack = 1'b0; bus.mem_err = 1'b0; bus.mem_rdata = '0;
    check("err_no_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("err_instr_kept", bus.instr, 32'h00B00113);
    fault_clear = 1'b1; step(); fault_clear = 1'b0;
    step();

    // Timeout (TIMEOUT=4): mem_req high 4 cycles, cleared by flush.
    push(K_REQ, 32'h10C, '0, 4);
    push(K_FAULT, 32'd3, 32'h10C, 0);
    pc = 32'h10C; start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    flush = 1'b1; step(); flush = 1'b0;
    check("tmo_clear", {29'd0, fault, fault_cause}, 32'd0);
    step();

    // Flush during BUSY: request held until ack, result dropped.
    push(K_REQ, 32'h110, '0, 4);
    pc = 32'h110; start = 1'b1; step(); start = 1'b0;
    step();
    flush = 1'b1; step(); flush = 1'b0;
    step();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEADBEEF; step();
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    for (int i = 0; i < 3; i++) step();
    check("flush_no_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("flush_no_fault", {31'd0, fault}, 32'd0);

    // Reset mid-request; late ack ignored.
    push(K_REQ, 32'h300, '0, 0);
    pc = 32'h300; start = 1'b1; step(); start = 1'b0;
    step();
    rst = 1'b1; step(); rst = 1'b0;
    check("mr_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("mr_mem_addr", bus.mem_addr, 32'd0);
    check("mr_instr", bus.instr, 32'd0);
    check("mr_instr_pc", bus.instr_pc, 32'd0);
    check("mr_outs", {28'd0, bus.instr_valid, pc_advance, fault_cause}, 32'd0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFEF00D; step();
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    step(); step();
    check("mr_late_ack", {30'd0, bus.instr_valid, fault}, 32'd0);

    check("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly downstream of the program counter.
- Takes the current PC value, performs a word fetch over a req/ack instruction-memory port, and holds the instruction until decode accepts it.
- On acceptance it issues a one-cycle pc_advance pulse, which drives the PC's update_en.
- Reports misaligned fetches, bus errors and fetch timeouts as faults instead of delivering an instruction.

Parameters:
XLEN, 32, width of addresses and instruction words
TIMEOUT, 255, max cycles in BUSY without mem_ack before timeout fault (1..255, fits 8-bit counter)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
pc  input  XLEN  current PC value
start  input  1  begin fetch at pc; honoured only in IDLE
flush  input  1  abandon current fetch / drop held instruction
mem_req  output  1  memory request, registered
mem_addr  output  XLEN  fetch address, registered, stable while mem_req=1
mem_ack  input  1  memory response valid
mem_err  input  1  bus error, qualified by mem_ack
mem_rdata  input  XLEN  read data, qualified by mem_ack
instr  output  XLEN  fetched instruction word
instr_pc  output  XLEN  address instr was fetched from
instr_valid  output  1  instr/instr_pc valid
instr_ready  input  1  decode accepts instr when high with instr_valid
pc_advance  output  1  one-cycle pulse to PC update_en after acceptance
fault  output  1  fetch fault pending
fault_cause  output  2  01 misaligned, 10 bus error, 11 timeout, 00 none
fault_clear  input  1  acknowledge fault, return to IDLE

Behaviour:
- Reset (rst=1 at edge): state IDLE.
  - All outputs 0: mem_req, mem_addr, instr, instr_pc, instr_valid, pc_advance, fault, fault_cause.
  - Timeout counter 0, discard flag 0.
  - rst overrides every other input in any state, including mid-request; the memory side must tolerate mem_req dropping on reset.
- States: IDLE, BUSY, DONE, FAULT.
- IDLE:
  - start=1, pc[1:0]!=0: no request; next state FAULT, fault=1, fault_cause=01, instr_pc<=pc.
  - start=1, pc aligned: mem_addr<=pc, instr_pc<=pc, mem_req<=1, counter<=0, next state BUSY. mem_req is visible the cycle after start.
  - flush in IDLE: no effect.
- BUSY:
  - mem_req and mem_addr held constant until the cycle mem_ack=1.
  - mem_req deasserts the cycle after ack.
  - Counter increments each cycle without ack.
  - mem_ack=1, mem_err=0, discard=0: instr<=mem_rdata, instr_valid<=1, next state DONE. Latency from ack to instr_valid is 1 cycle.
  - mem_ack=1, mem_err=1, discard=0: FAULT, cause 10; instr unchanged.
  - counter reaches TIMEOUT-1 with no ack: mem_req<=0, FAULT, cause 11. An ack arriving the same cycle as the timeout takes priority over the timeout.
  - flush=1 in BUSY: set discard=1. The request is not withdrawn (bus rule).
  - On the eventual ack with discard=1, data and error are ignored; return to IDLE and clear discard.
  - A timeout with discard=1 returns to IDLE with no fault.
- DONE:
  - instr_valid=1; instr and instr_pc stable.
  - instr_ready=1: instr_valid<=0, pc_advance<=1 for exactly one cycle, next state IDLE.
  - flush=1: instr_valid<=0, no pc_advance, IDLE. flush beats instr_ready when both are high.
- FAULT:
  - fault held, no memory activity.
  - fault_clear=1 or flush=1: fault<=0, fault_cause<=00, IDLE.
  - start is ignored while in FAULT.
- start outside IDLE is ignored and not queued.
- The earliest start after acceptance is the cycle after pc_advance, once pc has updated. A start issued in the pc_advance cycle itself is ignored.
- mem_addr is driven only from the latched pc; changes on pc during BUSY have no effect.
- Arithmetic: counter 8-bit unsigned, saturates (never wraps).

Test Plan:
- Aligned fetch: rst, start with pc=0x100, ack 3 cycles after mem_req with rdata=0x00A00093 -> mem_addr=0x100 stable throughout; instr=0x00A00093, instr_pc=0x100, instr_valid 1 cycle after ack; instr_ready -> single pc_advance pulse, IDLE.
- Back-pressure: instr_ready held 0 for 5 cycles after fetch of 0x104 -> instr_valid and instr stay stable, no pc_advance until ready=1.
- Misaligned: start with pc=0x102 -> mem_req never rises; fault=1, cause=01 next cycle; fault_clear -> fault=0, IDLE.
- Bus error and timeout: ack with mem_err=1 -> cause=10, instr_valid stays 0. Separately, no ack with TIMEOUT=4 -> mem_req drops after 4 BUSY cycles, cause=11.
- Flush during BUSY: flush 1 cycle after mem_req, ack 2 cycles later with rdata=0xDEADBEEF -> mem_req held until ack; instr_valid never asserts; IDLE; no pc_advance, no fault.
- Reset mid-request: rst asserted while in BUSY -> next cycle mem_req=0 and all outputs 0; a late ack is ignored.
